// File: rtl/dispatch8way.sv
// Single-slot token dispatcher feeding one of eight consumers in round-robin order.
// Define DISPATCH8WAY_SKIP_EN for work-conserving target selection; the default is strict round-robin.
module dispatch8way #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [7:0]       out_ready,
    output logic [7:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       select,
    output logic [15:0]      count
);

    localparam int unsigned NumWays = 8;
    localparam int unsigned PtrW    = 3;
    localparam int unsigned CountW  = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            stateQ;
    state_t            stateD;
    logic [PtrW-1:0]   ptrQ;
    logic [CountW-1:0] countQ;
    logic [WIDTH-1:0]  holdQ;
    logic [PtrW-1:0]   target;
    logic              outFire;
    logic              inReady;
    logic              inFire;

    // Consumer targeted by the held token this cycle
`ifdef DISPATCH8WAY_SKIP_EN
    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        target = ptrQ;
        idx    = ptrQ;
        found  = 1'b0;
        if (stateQ == FULL) begin
            for (int k = 0; k < int'(NumWays); k++) begin
                idx = ptrQ + PtrW'(k);
                if (!found && out_ready[idx]) begin
                    target = idx;
                    found  = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        target = ptrQ;
    end
`endif

    // Handshakes; reset suppresses both so a held token is dropped, not delivered
    always_comb begin
        outFire = (stateQ == FULL) && out_ready[target] && !reset;
        inReady = ((stateQ == EMPTY) || outFire) && !reset;
        inFire  = in_valid && inReady;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            EMPTY: if (inFire) stateD = FULL;
            FULL:  if (outFire && !inFire) stateD = EMPTY;
            default: stateD = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= EMPTY;
            ptrQ   <= '0;
            countQ <= '0;
            holdQ  <= '0;
        end else begin
            stateQ <= stateD;
            if (inFire) begin
                holdQ <= in_data;
            end
            if (outFire) begin
                ptrQ   <= target + PtrW'(1);
                countQ <= countQ + CountW'(1);
            end
        end
    end

    // Outputs forced quiet while reset is held, even before the first reset edge
    always_comb begin
        in_ready  = inReady;
        out_valid = '0;
        if ((stateQ == FULL) && !reset) begin
            out_valid = NumWays'(1) << target;
        end
        select   = reset ? '0 : target;
        out_data = reset ? '0 : holdQ;
        count    = countQ;
    end

endmodule

// File: tb/tb_dispatch8way.sv
// Directed bench for dispatch8way: reset, streaming, backpressure or skip, mid-operation reset, count wrap.
module tb_dispatch8way;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [7:0]  out_ready;
    logic [7:0]  out_valid;
    logic [15:0] out_data;
    logic [2:0]  select;
    logic [15:0] count;

    int compared;
    int mismatched;

    dispatch8way #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .select   (select),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1ns later
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] ev;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 16'hAAAA;
        out_ready  = 8'hFF;

        // Reset held two cycles with a pending producer
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'h00);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_select", 32'(select), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back streaming with all consumers ready
        for (int k = 1; k <= 17; k++) begin
            tick();
            in_valid = (k <= 16);
            in_data  = 16'(k);
            #1;
            if (k >= 2) begin
                ev = 8'h01 << ((k - 2) % 8);
                chk("str_out_valid", 32'(out_valid), 32'(ev));
                chk("str_out_data", 32'(out_data), 32'(k - 1));
                chk("str_select", 32'(select), 32'((k - 2) % 8));
                chk("str_count", 32'(count), 32'(k - 2));
            end
            chk("str_in_ready", 32'(in_ready), 32'd1);
        end
        tick();
        #1;
        chk("str_end_valid", 32'(out_valid), 32'h00);
        chk("str_end_count", 32'(count), 32'd16);
        chk("str_end_select", 32'(select), 32'd0);

`ifdef DISPATCH8WAY_SKIP_EN
        // Work-conserving skip: bring ptr to 6, then offer only consumer 3
        doReset();
        in_valid  = 1'b1;
        out_ready = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            in_data = 16'(16'h0100 + k);
            tick();
        end
        in_valid  = 1'b1;
        in_data   = 16'h0777;
        out_ready = 8'hFF;
        #1;
        chk("skp_pre_count", 32'(count), 32'd5);
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        #1;
        chk("skp_idle_select", 32'(select), 32'd6);
        chk("skp_idle_valid", 32'(out_valid), 32'h40);
        chk("skp_idle_data", 32'(out_data), 32'h0777);
        chk("skp_idle_ready", 32'(in_ready), 32'd0);
        chk("skp_idle_count", 32'(count), 32'd6);
        tick();
        out_ready = 8'h08;
        #1;
        chk("skp_select", 32'(select), 32'd3);
        chk("skp_valid", 32'(out_valid), 32'h08);
        chk("skp_in_ready", 32'(in_ready), 32'd1);
        tick();
        out_ready = 8'h00;
        #1;
        chk("skp_count", 32'(count), 32'd7);
        chk("skp_ptr", 32'(select), 32'd4);
        chk("skp_empty_valid", 32'(out_valid), 32'h00);
`else
        // Strict backpressure: token waits on consumer 0 while others are ready
        doReset();
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        out_ready = 8'hFE;
        #1;
        chk("bp_accept", 32'(in_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            in_data = 16'h5555;
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'h01);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'hBEEF);
            chk("bp_select", 32'(select), 32'd0);
            chk("bp_count", 32'(count), 32'd0);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h01;
        #1;
        chk("bp_fire_valid", 32'(out_valid), 32'h01);
        chk("bp_fire_ready", 32'(in_ready), 32'd1);
        tick();
        #1;
        chk("bp_count_after", 32'(count), 32'd1);
        chk("bp_ptr_after", 32'(select), 32'd1);
        chk("bp_valid_after", 32'(out_valid), 32'h00);
`endif

        // Reset while FULL drops the token without counting it
        doReset();
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 8'h00;
        tick();
        in_valid = 1'b0;
        #1;
        chk("mid_full_valid", 32'(out_valid), 32'h01);
        chk("mid_full_data", 32'(out_data), 32'h1234);
        reset     = 1'b1;
        out_ready = 8'hFF;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h00);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_post_valid", 32'(out_valid), 32'h00);
        chk("mid_post_count", 32'(count), 32'd0);
        chk("mid_post_ready", 32'(in_ready), 32'd1);
        tick();
        #1;
        chk("mid_post2_count", 32'(count), 32'd0);
        chk("mid_post2_valid", 32'(out_valid), 32'h00);

        // Count wrap after 65536 dispatches
        doReset();
        in_valid  = 1'b1;
        out_ready = 8'hFF;
        for (int j = 1; j <= 65536; j++) begin
            in_data = 16'(j);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("wrap_pre_count", 32'(count), 32'hFFFF);
        chk("wrap_pre_valid", 32'(out_valid), 32'h80);
        tick();
        #1;
        chk("wrap_count", 32'(count), 32'h0000);
        chk("wrap_select", 32'(select), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dispatch8way.md
DISPATCH8WAY -- requirements
Module: dispatch8way

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, token data width in bits.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port in_valid  input  1  producer offers a token.
REQ-005 SHALL provide port in_data  input  WIDTH  token payload.
REQ-006 SHALL provide port in_ready  output  1  block accepts token this cycle.
REQ-007 SHALL provide port out_ready  input  8  per-consumer ready, bit i = consumer i (A..H).
REQ-008 SHALL provide port out_valid  output  8  one-hot-or-zero valid, bit i = consumer i.
REQ-009 SHALL provide port out_data  output  WIDTH  held token, shared by all consumers.
REQ-010 SHALL provide port select  output  3  index of current target consumer.
REQ-011 SHALL provide port count  output  16  tokens dispatched since reset.

Function
REQ-012 SHALL hold at most one token in an internal register; states EMPTY and FULL.
REQ-013 SHALL define out_fire = FULL and out_ready[select]; in_fire = in_valid and in_ready.
REQ-014 SHALL drive in_ready = (EMPTY or out_fire) and not reset, combinationally.
REQ-015 SHALL drive out_valid[i] = FULL and (select == i); at most one bit set.
REQ-016 SHALL drive out_data from the holding register; value irrelevant when EMPTY but held stable while FULL.
REQ-017 SHALL capture in_data on in_fire; token visible on outputs the cycle after capture (1-cycle latency).
REQ-018 SHALL transition EMPTY->FULL on in_fire; FULL->EMPTY on out_fire without in_fire; FULL->FULL on simultaneous out_fire and in_fire (back-to-back, full throughput, new data replaces old).
REQ-019 SHALL keep a 3-bit round-robin pointer ptr; on out_fire ptr <= select + 1 modulo 8 (7 wraps to 0).
REQ-020 SHALL keep token and select stable while FULL and no out_fire (no retargeting mid-offer in strict mode).
REQ-021 SHALL increment count by 1 on each out_fire, wrapping 0xFFFF -> 0x0000.
REQ-022 SHALL ignore out_ready bits when EMPTY; no state change.

Reset
REQ-023 SHALL, on any clock edge with reset high, set state EMPTY, ptr 0, count 0, holding register 0.
REQ-024 SHALL hold in_ready 0, out_valid 0x00, select 0, out_data 0 while reset is high.
REQ-025 SHALL discard a held token if reset asserts mid-operation; no out_fire counted that cycle.

Configuration
REQ-026 SHALL use macro DISPATCH8WAY_SKIP_EN to select the target policy.
REQ-027 Without DISPATCH8WAY_SKIP_EN SHALL use strict round-robin: select = ptr; token waits on that consumer regardless of others.
REQ-028 With DISPATCH8WAY_SKIP_EN SHALL use work-conserving round-robin: while FULL, select = first index in circular order starting at ptr (inclusive) with out_ready set; if none set, select = ptr and no fire; select may change cycle to cycle while FULL.

Verification
REQ-029 Reset: reset high 2 cycles with in_valid=1 -> in_ready=0, out_valid=0x00, count=0, select=0; first cycle after release in_ready=1.
REQ-030 Streaming: out_ready=0xFF, in_valid=1, data 0x0001..0x0010 back-to-back -> one token per cycle, out_valid sequence 0x01,0x02,..,0x80,0x01.., count=16, select wraps 7->0.
REQ-031 Backpressure (strict): token 0xBEEF, out_ready=0xFE for 5 cycles -> out_valid=0x01 held, in_ready=0, data stable; out_ready=0x01 -> fire, count=1, ptr=1.
REQ-032 Skip (DISPATCH8WAY_SKIP_EN): ptr=6, out_ready=0x08 -> select=3, out_valid=0x08, fire, next ptr=4; out_ready=0x00 -> select=ptr, no fire.
REQ-033 Reset mid-operation: FULL with 0x1234, out_ready=0x00, assert reset 1 cycle -> EMPTY, out_valid=0x00, count unchanged from 0-reset value 0, token never delivered.
REQ-034 Count wrap: preload by 65535 dispatches, one more -> count=0x0000.
